// File: rtl/sm83_alu_serial_if.sv
// ============================================================================
// Module      : sm83_alu_serial_if
// Description : Command/response bundle between the decode sequencer and the
//               slice-serial SM83 ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sm83_alu_serial_if #(
  parameter int WORD_SIZE = 8
);
  logic                 start;
  logic [2:0]           op;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic                 carry_in;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] result;
  logic                 flag_z;
  logic                 flag_n;
  logic                 flag_h;
  logic                 flag_c;

  modport master (
    output start, op, op_a, op_b, carry_in,
    input  ready, busy, done, result, flag_z, flag_n, flag_h, flag_c
  );

  modport slave (
    input  start, op, op_a, op_b, carry_in,
    output ready, busy, done, result, flag_z, flag_n, flag_h, flag_c
  );
endinterface

`default_nettype wire

// File: rtl/sm83_alu_serial.sv
// ============================================================================
// Module      : sm83_alu_serial
// Description : SM83 ALU processing one SLICE_WIDTH slice per clock, LSB
//               first, with internal carry chaining and Z/N/H/C flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm83_alu_serial #(
  parameter int SLICE_WIDTH = 4,
  parameter int NUM_SLICES  = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  sm83_alu_serial_if.slave  bus
);

  localparam int WORD_SIZE = SLICE_WIDTH * NUM_SLICES;
  localparam int CNT_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_SLICES - 1);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_ADC = 3'd1;
  localparam logic [2:0] c_OP_SUB = 3'd2;
  localparam logic [2:0] c_OP_SBC = 3'd3;
  localparam logic [2:0] c_OP_AND = 3'd4;
  localparam logic [2:0] c_OP_XOR = 3'd5;
  localparam logic [2:0] c_OP_OR  = 3'd6;
  localparam logic [2:0] c_OP_CP  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_op;
  logic [WORD_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_b;
  logic [WORD_SIZE-1:0]   r_result;
  logic [CNT_W-1:0]       r_slice;
  logic                   r_carry;
  logic                   r_zacc;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_z;
  logic                   r_n;
  logic                   r_h;
  logic                   r_c;

  logic                   w_is_sub;
  logic                   w_is_logic;
  logic                   w_cin_eff;
  logic [SLICE_WIDTH-1:0] w_a_sl;
  logic [SLICE_WIDTH-1:0] w_b_raw;
  logic [SLICE_WIDTH-1:0] w_b_sl;
  logic [SLICE_WIDTH:0]   w_sum;
  logic [SLICE_WIDTH-1:0] w_slice_res;
  logic                   w_cout;
  logic                   w_slice_zero;
  logic                   w_flag_carry;
  logic [WORD_SIZE-1:0]   w_res_shift;

  assign w_is_sub   = (r_op == c_OP_SUB) || (r_op == c_OP_SBC) || (r_op == c_OP_CP);
  assign w_is_logic = (r_op == c_OP_AND) || (r_op == c_OP_XOR) || (r_op == c_OP_OR);

  // Operands shift right each cycle, so the active slice is always the low bits.
  assign w_a_sl  = r_a[SLICE_WIDTH-1:0];
  assign w_b_raw = r_b[SLICE_WIDTH-1:0];
  assign w_b_sl  = w_is_sub ? ~w_b_raw : w_b_raw;
  assign w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE_WIDTH{1'b0}}, r_carry};

  always_comb begin
    w_slice_res = w_sum[SLICE_WIDTH-1:0];
    case (r_op)
      c_OP_AND: w_slice_res = w_a_sl & w_b_raw;
      c_OP_XOR: w_slice_res = w_a_sl ^ w_b_raw;
      c_OP_OR:  w_slice_res = w_a_sl | w_b_raw;
      default:  w_slice_res = w_sum[SLICE_WIDTH-1:0];
    endcase
  end

  assign w_cout       = w_is_logic ? 1'b0 : w_sum[SLICE_WIDTH];
  assign w_slice_zero = (w_slice_res == '0);
  // Subtract ops report borrow, which is the inverse of the adder carry.
  assign w_flag_carry = w_cout ^ w_is_sub;

  always_comb begin
    w_cin_eff = 1'b0;
    case (bus.op)
      c_OP_ADC:          w_cin_eff = bus.carry_in;
      c_OP_SUB, c_OP_CP: w_cin_eff = 1'b1;
      c_OP_SBC:          w_cin_eff = ~bus.carry_in;
      default:           w_cin_eff = 1'b0;
    endcase
  end

  generate
    if (NUM_SLICES == 1) begin : g_single_slice
      assign w_res_shift = w_slice_res;
    end else begin : g_multi_slice
      assign w_res_shift = {w_slice_res, r_result[WORD_SIZE-1:SLICE_WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= c_OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_slice  <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_h      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && r_ready) begin
            r_op    <= bus.op;
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_carry <= w_cin_eff;
            r_slice <= '0;
            r_zacc  <= 1'b1;
            if (bus.op == c_OP_CP) begin
              r_result <= bus.op_a;
            end
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> SLICE_WIDTH;
          r_b     <= r_b >> SLICE_WIDTH;
          r_carry <= w_cout;
          r_zacc  <= r_zacc & w_slice_zero;
          r_slice <= r_slice + 1'b1;
          if (r_op != c_OP_CP) begin
            r_result <= w_res_shift;
          end
          if (r_slice == '0) begin
            r_h <= w_is_logic ? (r_op == c_OP_AND) : w_flag_carry;
          end
          if (r_slice == c_LAST) begin
            r_c     <= w_is_logic ? 1'b0 : w_flag_carry;
            r_z     <= r_zacc & w_slice_zero;
            r_n     <= w_is_sub;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.flag_z = r_z;
  assign bus.flag_n = r_n;
  assign bus.flag_h = r_h;
  assign bus.flag_c = r_c;

endmodule

`default_nettype wire

// File: tb/tb_sm83_alu_serial.sv
// ============================================================================
// Module      : tb_sm83_alu_serial
// Description : Scoreboard bench for sm83_alu_serial at 4x2 and 4x4 slicing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm83_alu_serial;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        h;
    logic        c;
    int          t;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   rdy_chk0 = 1'b0;
  bit   rdy_chk1 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  sm83_alu_serial_if #(.WORD_SIZE(8))  bus0();
  sm83_alu_serial_if #(.WORD_SIZE(16)) bus1();

  sm83_alu_serial #(.SLICE_WIDTH(4), .NUM_SLICES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  sm83_alu_serial #(.SLICE_WIDTH(4), .NUM_SLICES(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; SBC borrows carry_in, H is nibble carry/borrow.
  function automatic exp_t model(int w, logic [2:0] op, int a, int b, int cin);
    exp_t e;
    int mask, full, hfull, bw;
    mask = (1 << w) - 1;
    e.res = '0; e.z = 1'b0; e.n = 1'b0; e.h = 1'b0; e.c = 1'b0; e.t = 0;
    case (op)
      3'd0, 3'd1: begin
        bw    = (op == 3'd1) ? cin : 0;
        full  = a + b + bw;
        hfull = (a % 16) + (b % 16) + bw;
        e.res = 16'(full & mask);
        e.h   = (hfull > 15);
        e.c   = (full > mask);
        e.z   = (e.res == 16'd0);
      end
      3'd2, 3'd3, 3'd7: begin
        bw    = (op == 3'd3) ? cin : 0;
        full  = a - b - bw;
        hfull = (a % 16) - (b % 16) - bw;
        e.n   = 1'b1;
        e.h   = (hfull < 0);
        e.c   = (full < 0);
        e.z   = ((full & mask) == 0);
        e.res = (op == 3'd7) ? 16'(a) : 16'(full & mask);
      end
      3'd4: begin e.res = 16'(a & b); e.h = 1'b1; e.z = (e.res == 16'd0); end
      3'd5: begin e.res = 16'(a ^ b); e.z = (e.res == 16'd0); end
      default: begin e.res = 16'(a | b); e.z = (e.res == 16'd0); end
    endcase
    return e;
  endfunction

  task automatic check_done(int sel, logic [15:0] res, logic z, logic n, logic h, logic c);
    exp_t  e;
    string tag;
    int    depth;
    tag   = (sel == 0) ? "n2" : "n4";
    depth = (sel == 0) ? q0.size() : q1.size();
    if (depth == 0) begin
      chk({tag, "_unexpected_done"}, 16'(depth), 16'd1);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      chk({tag, "_result"},  res,     e.res);
      chk({tag, "_flag_z"},  16'(z),  16'(e.z));
      chk({tag, "_flag_n"},  16'(n),  16'(n === 1'bx ? 1'b0 : e.n));
      chk({tag, "_flag_h"},  16'(h),  16'(e.h));
      chk({tag, "_flag_c"},  16'(c),  16'(e.c));
      chk({tag, "_latency"}, 16'(cyc), 16'(e.t));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.done) begin
        check_done(0, 16'(bus0.result), bus0.flag_z, bus0.flag_n, bus0.flag_h, bus0.flag_c);
        rdy_chk0 = 1'b1;
      end else if (rdy_chk0) begin
        chk("n2_ready_after_done", 16'(bus0.ready), 16'd1);
        rdy_chk0 = 1'b0;
      end
      if (bus1.done) begin
        check_done(1, bus1.result, bus1.flag_z, bus1.flag_n, bus1.flag_h, bus1.flag_c);
        rdy_chk1 = 1'b1;
      end else if (rdy_chk1) begin
        chk("n4_ready_after_done", 16'(bus1.ready), 16'd1);
        rdy_chk1 = 1'b0;
      end
    end
  end

  task automatic wait_ready(int sel);
    int n;
    n = 0;
    while (((sel == 0) ? bus0.ready : bus1.ready) !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("ready_timeout", 16'((sel == 0) ? bus0.ready : bus1.ready), 16'd1);
  endtask

  task automatic issue(int sel, logic [2:0] op, logic [15:0] a, logic [15:0] b, logic cin, bit glitch);
    exp_t e;
    wait_ready(sel);
    e   = model((sel == 0) ? 8 : 16, op, int'(a), int'(b), int'(cin));
    e.t = cyc + 1 + ((sel == 0) ? 2 : 4);
    if (sel == 0) begin
      bus0.start = 1'b1; bus0.op = op; bus0.op_a = a[7:0]; bus0.op_b = b[7:0]; bus0.carry_in = cin;
      q0.push_back(e);
    end else begin
      bus1.start = 1'b1; bus1.op = op; bus1.op_a = a; bus1.op_b = b; bus1.carry_in = cin;
      q1.push_back(e);
    end
    @(negedge clk);
    // Scramble inputs after acceptance; the DUT must have latched them already.
    if (sel == 0) begin
      bus0.start = glitch; bus0.op = 3'($urandom); bus0.op_a = 8'($urandom);
      bus0.op_b = 8'($urandom); bus0.carry_in = 1'($urandom);
      chk("n2_busy_in_run", 16'(bus0.busy), 16'd1);
    end else begin
      bus1.start = glitch; bus1.op = 3'($urandom); bus1.op_a = 16'($urandom);
      bus1.op_b = 16'($urandom); bus1.carry_in = 1'($urandom);
      chk("n4_busy_in_run", 16'(bus1.busy), 16'd1);
    end
    if (glitch) begin
      @(negedge clk);
      if (sel == 0) bus0.start = 1'b0; else bus1.start = 1'b0;
    end
  endtask

  initial begin
    int n;
    bus0.start = 1'b0; bus0.op = 3'd0; bus0.op_a = '0; bus0.op_b = '0; bus0.carry_in = 1'b0;
    bus1.start = 1'b0; bus1.op = 3'd0; bus1.op_a = '0; bus1.op_b = '0; bus1.carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  16'(bus0.ready),  16'd1);
    chk("rst_busy",   16'(bus0.busy),   16'd0);
    chk("rst_done",   16'(bus0.done),   16'd0);
    chk("rst_result", 16'(bus0.result), 16'd0);
    chk("rst_flags",  16'({bus0.flag_z, bus0.flag_n, bus0.flag_h, bus0.flag_c}), 16'd0);
    chk("rst_result_n4", bus1.result, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 3'd0, 16'h3A, 16'hC6, 1'b0, 1'b0);
    issue(0, 3'd2, 16'h3E, 16'h0F, 1'b0, 1'b0);
    issue(0, 3'd7, 16'h3E, 16'h0F, 1'b0, 1'b0);
    issue(0, 3'd3, 16'h00, 16'h00, 1'b1, 1'b0);
    issue(0, 3'd1, 16'h0F, 16'h00, 1'b1, 1'b0);
    issue(0, 3'd4, 16'hF0, 16'h0F, 1'b0, 1'b0);
    issue(0, 3'd6, 16'h0F, 16'hF0, 1'b0, 1'b0);
    issue(0, 3'd5, 16'hAA, 16'hAA, 1'b0, 1'b0);
    issue(0, 3'd0, 16'h12, 16'h34, 1'b0, 1'b1);

    // Abort in the first RUN cycle: the accepted command must vanish.
    wait_ready(0);
    bus0.start = 1'b1; bus0.op = 3'd0; bus0.op_a = 8'h55; bus0.op_b = 8'h11; bus0.carry_in = 1'b0;
    @(negedge clk);
    bus0.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready",  16'(bus0.ready),  16'd1);
    chk("abort_busy",   16'(bus0.busy),   16'd0);
    chk("abort_done",   16'(bus0.done),   16'd0);
    chk("abort_result", 16'(bus0.result), 16'd0);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      issue(0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    issue(1, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      issue(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain", 16'(q0.size() + q1.size()), 16'd0);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
